// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - Iterative radix-2 Booth multiplier sequencer.
// Holds the {P_hi, P_lo, q_m1} shift register and drives an external Booth step stage.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] step_final,
  input  logic             step_ovf,
  output logic [WIDTH-1:0] step_current,
  output logic [WIDTH-1:0] step_multiplicand,
  output logic [WIDTH-1:0] step_not_multiplicand,
  output logic [1:0]       step_booth_bits,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic             q_m1_q, q_m1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] neg_m_q, neg_m_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             sum_sign;
  logic             done_exc;

  // The product fits only if the high word is a pure sign extension of the low word.
  assign done_exc = (p_hi_q != {WIDTH{p_lo_q[WIDTH-1]}});

  always_comb begin
    state_d  = state_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    q_m1_d   = q_m1_q;
    m_d      = m_q;
    neg_m_d  = neg_m_q;
    count_d  = count_q;
    result_d = result_q;
    exc_d    = exc_q;
    sum_sign = step_final[WIDTH-1] ^ step_ovf;

    case (state_q)
      RUN: begin
        p_hi_d  = {sum_sign, step_final[WIDTH-1:1]};
        p_lo_d  = {step_final[0], p_lo_q[WIDTH-1:1]};
        q_m1_d  = p_lo_q[0];
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        result_d = p_lo_q;
        exc_d    = done_exc;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A start wins in every state, aborting any operation in flight.
    if (ctrl_MULT) begin
      m_d     = data_operandA;
      neg_m_d = ~data_operandA + WIDTH'(1);
      p_hi_d  = '0;
      p_lo_d  = data_operandB;
      q_m1_d  = 1'b0;
      count_d = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      q_m1_q   <= 1'b0;
      m_q      <= '0;
      neg_m_q  <= '0;
      count_q  <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      q_m1_q   <= q_m1_d;
      m_q      <= m_d;
      neg_m_q  <= neg_m_d;
      count_q  <= count_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign step_current          = p_hi_q;
  assign step_multiplicand     = m_q;
  assign step_not_multiplicand = neg_m_q;
  assign step_booth_bits       = {p_lo_q[0], q_m1_q};

  // The result is shown live during DONE so it is valid alongside the ready pulse.
  assign data_result    = (state_q == DONE) ? p_lo_q : result_q;
  assign data_exception = (state_q == DONE) ? done_exc : exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - Self-checking bench for booth_mult_seq.
// Supplies the Booth step stage and compares against a signed-multiply model every cycle.
module tb_booth_mult_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic         ctrl_MULT = 1'b0;
  logic [W-1:0] step_final;
  logic         step_ovf;
  logic [W-1:0] step_current;
  logic [W-1:0] step_multiplicand;
  logic [W-1:0] step_not_multiplicand;
  logic [1:0]   step_booth_bits;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .data_operandA(data_operandA),
    .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT),
    .step_final(step_final),
    .step_ovf(step_ovf),
    .step_current(step_current),
    .step_multiplicand(step_multiplicand),
    .step_not_multiplicand(step_not_multiplicand),
    .step_booth_bits(step_booth_bits),
    .data_result(data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Booth step stage: overflow is judged as current+M or current-M, so the -2^31 case is exact.
  logic [W-1:0] step_sum;
  always_comb begin
    step_sum   = '0;
    step_final = step_current;
    step_ovf   = 1'b0;
    case (step_booth_bits)
      2'b01: begin
        step_sum   = step_current + step_multiplicand;
        step_final = step_sum;
        step_ovf   = (step_current[W-1] == step_multiplicand[W-1]) && (step_sum[W-1] != step_current[W-1]);
      end
      2'b10: begin
        step_sum   = step_current + step_not_multiplicand;
        step_final = step_sum;
        step_ovf   = (step_current[W-1] != step_multiplicand[W-1]) && (step_sum[W-1] != step_current[W-1]);
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // Model: an op accepted on a start edge shows ready once W edges later.
  logic         m_pend = 1'b0;
  int           m_cnt = 0;
  logic [W-1:0] m_op_a = '0;
  logic [W-1:0] m_op_res = '0;
  logic         m_op_exc = 1'b0;
  logic [W-1:0] m_held_res = '0;
  logic         m_held_exc = 1'b0;
  logic [63:0]  m_prod;

  assign m_prod = smul(data_operandA, data_operandB);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pend     <= 1'b0;
      m_cnt      <= 0;
      m_held_res <= '0;
      m_held_exc <= 1'b0;
    end else begin
      if (m_pend && m_cnt == W) begin
        m_held_res <= m_op_res;
        m_held_exc <= m_op_exc;
      end
      if (ctrl_MULT) begin
        m_pend   <= 1'b1;
        m_cnt    <= 0;
        m_op_a   <= data_operandA;
        m_op_res <= m_prod[W-1:0];
        m_op_exc <= (m_prod[63:W] != {(64-W){m_prod[W-1]}});
      end else if (m_pend) begin
        if (m_cnt == W) m_pend <= 1'b0;
        else m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clock) begin
    logic exp_rdy;
    logic exp_busy;
    exp_rdy  = m_pend && (m_cnt == W);
    exp_busy = m_pend && (m_cnt < W);
    check("ready", W'(data_resultRDY), W'(exp_rdy));
    check("busy", W'(busy), W'(exp_busy));
    check("result", data_result, exp_rdy ? m_op_res : m_held_res);
    check("exception", W'(data_exception), W'(exp_rdy ? m_op_exc : m_held_exc));
    if (exp_busy) begin
      check("multiplicand", step_multiplicand, m_op_a);
      check("not_multiplicand", step_not_multiplicand, -m_op_a);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Called just after the start edge; ready is sampled by a consumer on the 33rd edge.
  task automatic wait_ready(input string name, input logic [W-1:0] er, input logic ee);
    int edges;
    edges = 0;
    while (!data_resultRDY && edges < 60) begin
      tick();
      edges++;
    end
    check({name, " latency"}, W'(edges + 1), W'(W + 1));
    check({name, " lit result"}, data_result, er);
    check({name, " lit exc"}, W'(data_exception), W'(ee));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ee);
    start(a, b);
    wait_ready(name, er, ee);
    tick();
    check({name, " pulse width"}, W'(data_resultRDY), 32'd0);
    tick();
  endtask

  initial begin
    #1;
    check("reset busy", W'(busy), 32'd0);
    check("reset result", data_result, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    run_op("3x5", 32'd3, 32'd5, 32'h0000000F, 1'b0);
    run_op("-7x6", 32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0);
    run_op("6x-7", 32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 1'b0);
    run_op("min x -1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op("min x 1", 32'h80000000, 32'd1, 32'h80000000, 1'b0);
    run_op("2^16 sq", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    run_op("max x 0", 32'h7FFFFFFF, 32'd0, 32'h00000000, 1'b0);
    run_op("-1 x -1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);

    start(32'd3, 32'd5);
    repeat (9) tick();
    start(32'd4, 32'd4);
    wait_ready("abort", 32'h00000010, 1'b0);
    repeat (3) tick();

    start(32'd3, 32'd5);
    repeat (14) tick();
    reset = 1'b1;
    #1;
    check("mid reset busy", W'(busy), 32'd0);
    check("mid reset rdy", W'(data_resultRDY), 32'd0);
    check("mid reset result", data_result, 32'd0);
    check("mid reset exc", W'(data_exception), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_op("2x2 after reset", 32'd2, 32'd2, 32'h00000004, 1'b0);

    start(32'd3, 32'd5);
    wait_ready("pre done-start", 32'h0000000F, 1'b0);
    start(32'd7, 32'd7);
    wait_ready("done-start", 32'h00000031, 1'b0);
    repeat (2) tick();

    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT = 1'b1;
    tick();
    data_operandA = 32'd8;
    tick();
    start(32'd5, 32'd5);
    wait_ready("held start", 32'h00000019, 1'b0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
